// File: rtl/decade_pkg.sv
// Shared constants for the decade counter chain: FSM encodings and BCD digit limits.
package decade_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 on inc, carries out when incremented at 9.
module bcd_digit
  import decade_pkg::*;
(
  input  logic             cp,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign cout  = inc & (digit_q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run/stop controller for a cascaded BCD counter chain with edge-detected count events,
// programmable target match and sticky wrap flag.
module decade_chain_ctrl
  import decade_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    cp,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    x,
  input  logic [BCD_W*DIGITS-1:0] target,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    q,
  output logic                    busy,
  output logic                    ovf
);

  logic [1:0]        state_q, state_d;
  logic              x_q;
  logic              ovf_q, ovf_d;
  logic              x_rise, count_en, digit_clr, match, wrap;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] hit;

  assign x_rise    = x & ~x_q;
  assign count_en  = x_rise & (state_q == ST_RUN) & ~clear;
  assign digit_clr = clear | ((state_q == ST_DONE) & start);
  assign carry[0]  = count_en;
  assign wrap      = carry[DIGITS];
  assign match     = &hit;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] dig, nxt;

    bcd_digit u_digit (
      .cp    (cp),
      .reset (reset),
      .clr   (digit_clr),
      .inc   (carry[i]),
      .digit (dig),
      .cout  (carry[i+1])
    );

    // Post-increment digit value, so the target compare sees the count being registered.
    assign nxt = carry[i] ? ((dig == BCD_MAX) ? '0 : dig + BCD_W'(1)) : dig;
    assign hit[i] = (nxt == target[BCD_W*i +: BCD_W]);
    assign bcd[BCD_W*i +: BCD_W] = dig;
  end

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_IDLE;
      ovf_d   = 1'b0;
    end else begin
      if (count_en && wrap) ovf_d = 1'b1;
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (count_en && match) state_d = ST_DONE;
          else if (stop)         state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start) state_d = ST_RUN;
        ST_DONE:  if (start) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cp or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = (state_q == ST_DONE);
  assign busy = (state_q == ST_RUN);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Bench for decade_chain_ctrl: directed scenarios plus random commands, checked
// against an integer-count reference model.
module tb_decade_chain_ctrl;

  localparam int unsigned DIGITS = 2;
  localparam int MAXV = 100;

  logic       cp = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, x = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] bcd;
  logic       q, busy, ovf;

  int total = 0;
  int bad = 0;

  // Reference model: count as a plain integer, state as a small code.
  int m_cnt, m_st;  // m_st: 0 idle, 1 run, 2 pause, 3 done
  bit m_ovf, m_xd;

  decade_chain_ctrl #(.DIGITS(DIGITS)) dut (
    .cp     (cp),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .x      (x),
    .target (target),
    .bcd    (bcd),
    .q      (q),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #10 cp = ~cp;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'((v % 10));
    r[7:4] = 4'(((v / 10) % 10));
    return r;
  endfunction

  function automatic int tgt_val(input logic [7:0] t);
    int v = 0;
    int w = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (t[4*i +: 4] > 4'd9) return -1;
      v += int'(t[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_ovf = 0; m_xd = 0;
  endtask

  task automatic model_update();
    bit rise;
    rise = x && !m_xd;
    m_xd = x;
    if (clear) begin
      m_cnt = 0; m_ovf = 0; m_st = 0;
    end else begin
      case (m_st)
        0: if (start) m_st = 1;
        1: begin
          if (rise) begin
            m_cnt++;
            if (m_cnt == MAXV) begin
              m_cnt = 0;
              m_ovf = 1;
            end
            if (m_cnt == tgt_val(target)) m_st = 3;
            else if (stop) m_st = 2;
          end else if (stop) begin
            m_st = 2;
          end
        end
        2: if (start) m_st = 1;
        default: if (start) begin
          m_cnt = 0;
          m_st = 1;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd", bcd, to_bcd(m_cnt));
    chk("q", 8'(q), 8'(m_st == 3));
    chk("busy", 8'(busy), 8'(m_st == 1));
    chk("ovf", 8'(ovf), 8'(m_ovf));
  endtask

  task automatic tick();
    @(posedge cp);
    if (reset) model_reset();
    else model_update();
    #1;
    check_all();
  endtask

  task automatic pulse();
    x = 1'b1; tick();
    x = 1'b0; tick(); tick(); tick();
  endtask

  task automatic cmd_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic cmd_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic cmd_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();

    // 1. Reset held with x toggling
    for (int i = 0; i < 3; i++) begin
      x = ~x; tick();
    end
    x = 1'b0;
    reset = 1'b0;
    tick();
    chk("t1_bcd", bcd, 8'h00);

    // 2. Count to target 12, freeze, restart
    target = 8'h12;
    cmd_start();
    for (int i = 0; i < 12; i++) pulse();
    chk("t2_bcd12", bcd, 8'h12);
    chk("t2_q", 8'(q), 8'd1);
    for (int i = 0; i < 3; i++) pulse();
    chk("t2_frozen", bcd, 8'h12);
    cmd_start();
    chk("t2_restart_bcd", bcd, 8'h00);
    chk("t2_restart_busy", 8'(busy), 8'd1);

    // 3. Wrap with an unreachable target
    target = 8'hAA;
    for (int i = 0; i < 99; i++) pulse();
    chk("t3_bcd99", bcd, 8'h99);
    pulse();
    chk("t3_wrap_bcd", bcd, 8'h00);
    chk("t3_wrap_ovf", 8'(ovf), 8'd1);
    for (int i = 0; i < 5; i++) pulse();
    chk("t3_bcd05", bcd, 8'h05);
    chk("t3_ovf_sticky", 8'(ovf), 8'd1);

    // 4. Pause at 05
    cmd_stop();
    for (int i = 0; i < 3; i++) pulse();
    chk("t4_hold", bcd, 8'h05);
    chk("t4_busy", 8'(busy), 8'd0);
    cmd_start();
    pulse();
    chk("t4_resume", bcd, 8'h06);

    // 5. Held x, stop with rise, clear with rise
    x = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    x = 1'b0; tick();
    chk("t5_held_once", bcd, 8'h07);
    x = 1'b1; stop = 1'b1; tick();
    x = 1'b0; stop = 1'b0; tick();
    chk("t5_stop_rise_bcd", bcd, 8'h08);
    chk("t5_stop_rise_busy", 8'(busy), 8'd0);
    cmd_start();
    x = 1'b1; clear = 1'b1; tick();
    x = 1'b0; clear = 1'b0; tick();
    chk("t5_clear_rise", bcd, 8'h00);
    chk("t5_clear_ovf", 8'(ovf), 8'd0);

    // 6. Async reset mid-run
    cmd_start();
    for (int i = 0; i < 7; i++) pulse();
    chk("t6_bcd07", bcd, 8'h07);
    #4 reset = 1'b1;
    #1;
    model_reset();
    chk("t6_async_bcd", bcd, 8'h00);
    chk("t6_async_busy", 8'(busy), 8'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    chk("t6_no_count", bcd, 8'h00);

    // Random commands, events and targets
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 99) == 0);
      x     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 3) == 0) target = 8'($urandom);
        else target = to_bcd(int'($urandom_range(0, MAXV - 1)));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
